rr_bus_scheduler: RTL and testbench

//  Round-robin scheduler for the shared serial bus (b_BUS/b_RW/b_bus_utilizing).

---
 rtl/rr_bus_scheduler.sv | 119 +++++++++++
 tb/tb_rr_bus_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_bus_scheduler.sv
// Round-robin scheduler for the shared serial bus with start/hold watchdogs.
// Ports: clk, rst (async high), m_reqs, bus_util (low = tenure), m_grants, mid_current, state, timeout.
module rr_bus_scheduler #(
  parameter int N_MASTERS    = 12,
  parameter int MID_WIDTH    = 4,
  parameter int START_TO_LEN = 6,
  parameter int HOLD_TO_LEN  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] m_reqs,
  input  logic                 bus_util,
  output logic [N_MASTERS-1:0] m_grants,
  output logic [MID_WIDTH-1:0] mid_current,
  output logic [3:0]           state,
  output logic                 timeout
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    GRANT   = 4'd1,
    ACTIVE  = 4'd2,
    RELEASE = 4'd3
  } state_t;

  localparam logic [N_MASTERS-1:0] ONE = N_MASTERS'(1);
  localparam logic [MID_WIDTH:0]   NM  = (MID_WIDTH+1)'(N_MASTERS);

  state_t                  st;
  logic [MID_WIDTH-1:0]    ptr;
  logic [MID_WIDTH-1:0]    sel;
  logic                    any_req;
  logic [MID_WIDTH:0]      idx;
  logic [START_TO_LEN-1:0] start_cnt;
  logic [HOLD_TO_LEN-1:0]  hold_cnt;

  assign state = st;

  // First requester after ptr, wrapping at N_MASTERS.
  always_comb begin
    sel     = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      idx = {1'b0, ptr} + (MID_WIDTH+1)'(i);
      if (idx >= NM)
        idx = idx - NM;
      if (!any_req && m_reqs[idx[MID_WIDTH-1:0]]) begin
        any_req = 1'b1;
        sel     = idx[MID_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= IDLE;
      m_grants    <= '0;
      mid_current <= '0;
      ptr         <= MID_WIDTH'(N_MASTERS-1);
      start_cnt   <= '0;
      hold_cnt    <= '0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (st)
        IDLE: begin
          if (any_req) begin
            m_grants    <= ONE << sel;
            mid_current <= sel;
            start_cnt   <= '0;
            st          <= GRANT;
          end
        end
        GRANT: begin
          if (!bus_util) begin
            start_cnt <= '0;
            hold_cnt  <= '0;
            st        <= ACTIVE;
          end else if (!m_reqs[mid_current]) begin
            m_grants <= '0;
            st       <= RELEASE;
          end else if (&start_cnt) begin
            timeout  <= 1'b1;
            m_grants <= '0;
            st       <= RELEASE;
          end else begin
            start_cnt <= start_cnt + 1'b1;
          end
        end
        ACTIVE: begin
          if (bus_util) begin
            m_grants <= '0;
            st       <= RELEASE;
          end else if (&hold_cnt) begin
            timeout  <= 1'b1;
            m_grants <= '0;
            st       <= RELEASE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RELEASE: begin
          // Grant already dropped on entry; this is the turnaround clock.
          ptr       <= mid_current;
          start_cnt <= '0;
          hold_cnt  <= '0;
          m_grants  <= '0;
          st        <= IDLE;
        end
        default: begin
          m_grants <= '0;
          st       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_bus_scheduler.sv
// Bench for rr_bus_scheduler: vector table, directed sequences, random vs model.
// Model tracks tenure phase and cycles spent in it, not the RTL counters.
module tb_rr_bus_scheduler;

  localparam int N  = 12;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  m_reqs = '0;
  logic          bus_util = 1'b1;
  logic [N-1:0]  m_grants;
  logic [MW-1:0] mid_current;
  logic [3:0]    state;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  rr_bus_scheduler #(
    .N_MASTERS(N), .MID_WIDTH(MW),
    .START_TO_LEN(6), .HOLD_TO_LEN(10)
  ) dut (
    .clk(clk), .rst(rst), .m_reqs(m_reqs), .bus_util(bus_util),
    .m_grants(m_grants), .mid_current(mid_current),
    .state(state), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  int ms;    // phase: 0 idle,1 grant,2 active,3 release
  int mh;    // current/last holder
  int ml;    // last completed holder
  int mage;  // cycles spent in current phase
  bit mto;

  function automatic int pick(logic [N-1:0] r, int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    ms = 0; mh = 0; ml = N - 1; mage = 0; mto = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic u);
    mto = 0;
    case (ms)
      0: if (r != 0) begin mh = pick(r, ml); ms = 1; mage = 0; end
      1: begin
        mage++;
        if (!u) begin ms = 2; mage = 0; end
        else if (!r[mh]) ms = 3;
        else if (mage == 64) begin mto = 1; ms = 3; end
      end
      2: begin
        mage++;
        if (u) ms = 3;
        else if (mage == 1024) begin mto = 1; ms = 3; end
      end
      default: begin ml = mh; ms = 0; mage = 0; end
    endcase
  endtask

  function automatic logic [N-1:0] exp_g();
    logic [N-1:0] one;
    one = 1;
    return (ms == 1 || ms == 2) ? (one << mh) : '0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string nm);
    checks++;
    if (m_grants !== exp_g() || mid_current !== 4'(mh) ||
        state !== 4'(ms) || timeout !== mto) begin
      errors++;
      $display("FAIL %s got g=%h mid=%0d st=%0d to=%b expected g=%h mid=%0d st=%0d to=%b",
               nm, m_grants, mid_current, state, timeout,
               exp_g(), mh, ms, mto);
    end
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic u);
    m_reqs = r;
    bus_util = u;
    @(posedge clk);
    model_step(r, u);
    @(negedge clk);
    chk_model("model");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reqs = '0;
    bus_util = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_grants", 32'(m_grants), 0);
    chk("rst_mid", 32'(mid_current), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_timeout", 32'(timeout), 0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]  reqs;
    logic          util;
    logic [N-1:0]  g;
    logic [MW-1:0] mid;
    logic [3:0]    st;
    logic          to;
  } vec_t;

  vec_t vt[11];
  int   order[$];
  int   exp_order[5];

  initial begin
    logic [N-1:0] prev_g;
    logic         u;
    int           zero_run, lowcnt, ng, na;
    bit           seen;

    vt[0]  = '{12'h008, 1'b1, 12'h008, 4'd3, 4'd1, 1'b0};
    vt[1]  = '{12'h000, 1'b1, 12'h000, 4'd3, 4'd3, 1'b0};
    vt[2]  = '{12'h002, 1'b1, 12'h000, 4'd3, 4'd0, 1'b0};
    vt[3]  = '{12'h002, 1'b1, 12'h002, 4'd1, 4'd1, 1'b0};
    vt[4]  = '{12'h000, 1'b1, 12'h000, 4'd1, 4'd3, 1'b0};
    vt[5]  = '{12'h003, 1'b1, 12'h000, 4'd1, 4'd0, 1'b0};
    vt[6]  = '{12'h003, 1'b1, 12'h001, 4'd0, 4'd1, 1'b0};
    vt[7]  = '{12'h003, 1'b0, 12'h001, 4'd0, 4'd2, 1'b0};
    vt[8]  = '{12'h000, 1'b0, 12'h001, 4'd0, 4'd2, 1'b0};
    vt[9]  = '{12'h000, 1'b1, 12'h000, 4'd0, 4'd3, 1'b0};
    vt[10] = '{12'h000, 1'b1, 12'h000, 4'd0, 4'd0, 1'b0};
    exp_order = '{0, 4, 5, 0, 4};

    // Table: first grant, withdrawal in GRANT, pointer after release.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      cyc(vt[i].reqs, vt[i].util);
      chk($sformatf("vec%0d_g", i), 32'(m_grants), 32'(vt[i].g));
      chk($sformatf("vec%0d_mid", i), 32'(mid_current), 32'(vt[i].mid));
      chk($sformatf("vec%0d_st", i), 32'(state), 32'(vt[i].st));
      chk($sformatf("vec%0d_to", i), 32'(timeout), 32'(vt[i].to));
    end

    // Round-robin order with 5-clk tenures.
    do_reset();
    prev_g = '0; zero_run = 0; lowcnt = 0;
    for (int c = 0; c < 200 && order.size() < 5; c++) begin
      if (ms == 1) begin u = 1'b0; lowcnt = 1; end
      else if (ms == 2 && lowcnt < 5) begin u = 1'b0; lowcnt++; end
      else u = 1'b1;
      cyc(12'h031, u);
      if (m_grants != 0 && prev_g == 0) begin
        order.push_back(int'(mid_current));
        if (order.size() > 1) chk("rr_gap", 32'(zero_run), 2);
      end
      zero_run = (m_grants == 0) ? zero_run + 1 : 0;
      prev_g = m_grants;
    end
    chk("rr_count", 32'(order.size()), 5);
    for (int i = 0; i < 5 && i < order.size(); i++)
      chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));

    // Start watchdog.
    do_reset();
    cyc(12'h010, 1'b1);
    ng = (state == 4'd1) ? 1 : 0;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      cyc(12'h010, 1'b1);
      if (state == 4'd1) ng++;
      if (timeout) seen = 1;
    end
    chk("start_to_seen", 32'(seen), 1);
    chk("start_to_cycles", 32'(ng), 64);
    chk("start_to_grant", 32'(m_grants), 0);
    cyc(12'h010, 1'b1);
    chk("start_to_to_pulse", 32'(timeout), 0);
    cyc(12'h010, 1'b1);
    chk("start_regrant", 32'(m_grants), 32'h010);

    // Hold watchdog.
    do_reset();
    cyc(12'h020, 1'b1);
    cyc(12'h020, 1'b0);
    na = (state == 4'd2) ? 1 : 0;
    seen = 0;
    for (int c = 0; c < 1100 && !seen; c++) begin
      cyc(12'h020, 1'b0);
      if (state == 4'd2) na++;
      if (timeout) seen = 1;
    end
    chk("hold_to_seen", 32'(seen), 1);
    chk("hold_to_cycles", 32'(na), 1024);
    chk("hold_to_grant", 32'(m_grants), 0);
    cyc(12'h000, 1'b1);
    cyc(12'h000, 1'b1);

    // Async reset mid-ACTIVE.
    do_reset();
    cyc(12'h004, 1'b1);
    cyc(12'h004, 1'b0);
    cyc(12'h004, 1'b0);
    chk("arst_pre_g", 32'(m_grants), 32'h004);
    #2 rst = 1'b1;
    #1;
    chk("arst_g", 32'(m_grants), 0);
    chk("arst_mid", 32'(mid_current), 0);
    chk("arst_st", 32'(state), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(12'h005, 1'b1);
    chk("arst_next", 32'(m_grants), 32'h001);

    // Random traffic against the model.
    do_reset();
    u = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] r;
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = N'(1) << $urandom_range(0, N - 1);
        default: r = N'($urandom);
      endcase
      if ($urandom_range(0, 5) == 0) u = ~u;
      if ($urandom_range(0, 499) == 0) do_reset();
      else cyc(r, u);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
